// File: rtl/tick_gen_if.sv
// tick_gen_if -- configuration handshake bundle for tick_gen.
//   cfg_valid  master->slave  configuration offer
//   cfg_ready  slave->master  configuration accepted when valid & ready
//   cfg_div    master->slave  tick period minus one
//   cfg_burst  master->slave  burst length minus one
//   cfg_mode   master->slave  0 = continuous, 1 = burst
interface tick_gen_if #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 4
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [DIV_W-1:0]   cfg_div;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_burst,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_burst,
        input  cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/tick_gen.sv
// tick_gen -- programmable prescaler producing a one-cycle enable pulse for a
// downstream up-counter. Runs continuously or emits a fixed-length burst.
// Configuration is accepted over a valid/ready handshake while idle.
//
// Ports:
//   clock       posedge clock for all logic
//   reset       synchronous, active-high
//   cfg         tick_gen_if.slave configuration handshake (ready only in IDLE)
//   start       begin ticking, honoured in IDLE only
//   stop        abort run, honoured in RUN only (wins over a terminal count)
//   pause       (only with TICK_GEN_PAUSE_EN) freezes the prescaler in RUN
//   tick        one-cycle enable pulse, period cfg_div+1 clocks
//   busy        high in RUN
//   done        one-cycle pulse after the last tick of a burst
//   tick_count  ticks emitted this run, wraps modulo 2^BURST_W
//
// Build option: define TICK_GEN_PAUSE_EN to add the pause input.
//
// state  | meaning
// IDLE   | configurable, waiting for start
// RUN    | prescaler counting, ticks being issued
// DONE   | burst finished, done pulse visible for one cycle
module tick_gen #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    tick_gen_if.slave          cfg,
    input  logic               start,
    input  logic               stop,
`ifdef TICK_GEN_PAUSE_EN
    input  logic               pause,
`endif
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] tick_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_r, div_nxt;
    logic [BURST_W-1:0] burst_r, burst_nxt;
    logic               mode_r, mode_nxt;
    logic [DIV_W-1:0]   cnt, cnt_nxt;
    logic               tick_nxt, busy_nxt, done_nxt;
    logic [BURST_W-1:0] tick_count_nxt;
    // Set when the final burst tick is launched; the run ends on the edge at
    // which the downstream counter consumes that tick.
    logic               last_r, last_nxt;
    logic               pause_w;

`ifdef TICK_GEN_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign cfg.cfg_ready = (state == S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (stop)                  state_nxt = S_IDLE;
                else if (!pause_w && last_r) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        div_nxt        = div_r;
        burst_nxt      = burst_r;
        mode_nxt       = mode_r;
        cnt_nxt        = cnt;
        tick_nxt       = 1'b0;
        tick_count_nxt = tick_count;
        last_nxt       = last_r;
        case (state)
            S_IDLE: begin
                if (cfg.cfg_valid) begin
                    div_nxt   = cfg.cfg_div;
                    burst_nxt = cfg.cfg_burst;
                    mode_nxt  = cfg.cfg_mode;
                end
                if (start) begin
                    cnt_nxt        = '0;
                    tick_count_nxt = '0;
                    last_nxt       = 1'b0;
                end
            end
            S_RUN: begin
                // No new tick once the last burst tick is out, otherwise
                // div=0 would leak one extra tick on the way to DONE.
                if (!stop && !pause_w && !last_r) begin
                    if (cnt == div_r) begin
                        cnt_nxt        = '0;
                        tick_nxt       = 1'b1;
                        tick_count_nxt = tick_count + 1'b1;
                        last_nxt       = mode_r && (tick_count == burst_r);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                last_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_r      <= '0;
            burst_r    <= '0;
            mode_r     <= 1'b0;
            cnt        <= '0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick_count <= '0;
            last_r     <= 1'b0;
        end else begin
            div_r      <= div_nxt;
            burst_r    <= burst_nxt;
            mode_r     <= mode_nxt;
            cnt        <= cnt_nxt;
            tick       <= tick_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            tick_count <= tick_count_nxt;
            last_r     <= last_nxt;
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen -- directed self-checking bench for tick_gen.
// Cycle k is the state visible just after the k-th rising edge following the
// edge that samples start (that edge is edge 0).
module tb_tick_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       tick;
    logic       busy;
    logic       done;
    logic [3:0] tick_count;

    int checks   = 0;
    int failures = 0;

    tick_gen_if #(.DIV_W(8), .BURST_W(4)) cfg_bus ();

    tick_gen #(.DIV_W(8), .BURST_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg        (cfg_bus.slave),
        .start      (start),
        .stop       (stop),
`ifdef TICK_GEN_PAUSE_EN
        .pause      (pause),
`endif
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .tick_count (tick_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer configuration together with start; returns just after edge 0.
    task automatic cfg_start(input logic [7:0] div, input logic [3:0] burst, input logic mode);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = div;
        cfg_bus.cfg_burst = burst;
        cfg_bus.cfg_mode  = mode;
        start             = 1'b1;
        step();
        cfg_bus.cfg_valid = 1'b0;
        start             = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        stop              = 1'b0;
        pause             = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_burst = '0;
        cfg_bus.cfg_mode  = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", tick_count, 0);
        chk("rst_ready", cfg_bus.cfg_ready, 1);

        // 1: reset in the middle of a continuous run
        cfg_start(8'd3, 4'd0, 1'b0);
        for (int k = 1; k <= 5; k++) step();
        chk("t1_busy_before", busy, 1);
        chk("t1_count_before", tick_count, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t1_tick", tick, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_count", tick_count, 0);
        chk("t1_ready", cfg_bus.cfg_ready, 1);

        // 2: div=0 ticks every cycle, tick_count wraps 15 -> 0
        cfg_start(8'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("t2_tick", tick, 1);
            chk("t2_count", tick_count, 32'(k % 16));
        end
        do_stop();
        chk("t2_stop_tick", tick, 0);
        chk("t2_stop_busy", busy, 0);
        chk("t2_stop_count", tick_count, 1);

        // 3: burst of 4 ticks, period 3
        cfg_start(8'd2, 4'd3, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("t3_tick", tick, (k % 3 == 0 && k <= 12) ? 1 : 0);
            chk("t3_done", done, (k == 13) ? 1 : 0);
            chk("t3_busy", busy, (k <= 12) ? 1 : 0);
            chk("t3_ready", cfg_bus.cfg_ready, (k >= 14) ? 1 : 0);
        end
        chk("t3_count", tick_count, 4);

        // 4: stop on the terminal-count cycle suppresses that tick
        cfg_start(8'd4, 4'd0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("t4_tick", tick, (k == 5) ? 1 : 0);
        end
        do_stop();
        chk("t4_stop_tick", tick, 0);
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_ready", cfg_bus.cfg_ready, 1);
        chk("t4_stop_count", tick_count, 1);
        step();
        chk("t4_no_done", done, 0);
        chk("t4_idle_tick", tick, 0);

        // 5: config with start uses new div; config during RUN ignored
        cfg_start(8'd1, 4'd0, 1'b0);
        step();
        chk("t5_c1_tick", tick, 0);
        chk("t5_c1_ready", cfg_bus.cfg_ready, 0);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = 8'd5;
        step();
        cfg_bus.cfg_valid = 1'b0;
        chk("t5_c2_tick", tick, 1);
        step();
        chk("t5_c3_tick", tick, 0);
        step();
        chk("t5_c4_tick", tick, 1);
        do_stop();
        chk("t5_stop_busy", busy, 0);

`ifdef TICK_GEN_PAUSE_EN
        // 6: pause for 5 cycles mid-period stretches the gap by 5
        cfg_start(8'd3, 4'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t6_tick", tick, (k % 4 == 0) ? 1 : 0);
        end
        pause = 1'b1;
        for (int k = 9; k <= 13; k++) begin
            step();
            chk("t6_pause_tick", tick, 0);
            chk("t6_pause_busy", busy, 1);
        end
        pause = 1'b0;
        for (int k = 14; k <= 17; k++) begin
            step();
            chk("t6_resume_tick", tick, (k == 17) ? 1 : 0);
        end
        chk("t6_count", tick_count, 3);
        do_stop();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
